// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher definitions.
//   NR               : round count for AES-128
//   fsm_t            : iterative core control states
//   blk_t            : 128-bit block viewed as bytes; element i is FIPS-197
//                      byte i (column-major, i = 4*col + row), byte 0 at MSB
//   xtime/gf_mul     : GF(2^8) arithmetic, reduction polynomial 0x11b
//   inv_shift_rows   : row r rotated right by r byte positions
//   inv_mix_columns  : per-column matrix {0e,0b,0d,09}
package aes_pkg;

  localparam int unsigned NR = 10;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } fsm_t;

  typedef logic [0:15][7:0] blk_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    blk_t in_b;
    blk_t out_b;
    in_b  = s;
    out_b = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        out_b[4'(4 * c + r)] = in_b[4'(4 * ((c + 4 - r) % 4) + r)];
      end
    end
    return out_b;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    blk_t in_b;
    blk_t out_b;
    logic [7:0] a0, a1, a2, a3;
    in_b  = s;
    out_b = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = in_b[4'(4 * c)];
      a1 = in_b[4'(4 * c + 1)];
      a2 = in_b[4'(4 * c + 2)];
      a3 = in_b[4'(4 * c + 3)];
      out_b[4'(4 * c)]     = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      out_b[4'(4 * c + 1)] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      out_b[4'(4 * c + 2)] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      out_b[4'(4 * c + 3)] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return out_b;
  endfunction

endpackage

// File: rtl/inv_s_box.sv
// Combinational AES inverse S-box.
//   value   : input byte
//   inverse : InvSubBytes(value)
module inv_s_box (
  input  logic [7:0] value,
  output logic [7:0] inverse
);

  // Entry for byte v sits at bits [8*(255-v) +: 8]; 255-v is ~v for 8 bits.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign inverse = INV_SBOX[{~value, 3'b000} +: 8];

endmodule

// File: rtl/inv_cipher_core.sv
// Iterative AES-128 inverse cipher, one round per clock.
//   clk, rst_n         : clock, asynchronous active-low reset
//   valid_i / ready_o  : ciphertext input handshake (state_i)
//   rk_idx_o / rk_i    : combinational round-key lookup into external store
//   valid_o / ready_i  : plaintext output handshake (state_o, held until taken)
// Block byte order: FIPS-197 byte i at [127-8i -: 8], column-major.
module inv_cipher_core
  import aes_pkg::*;
#(
  parameter int unsigned NR = aes_pkg::NR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [127:0] state_i,
  output logic [3:0]   rk_idx_o,
  input  logic [127:0] rk_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [127:0] state_o
);

  fsm_t         fsm;
  fsm_t         fsm_nxt;
  logic [3:0]   cnt;
  logic [127:0] st;

  blk_t         isr_b;
  blk_t         isb_b;
  logic [127:0] ark;
  logic [127:0] round_out;

  // Shared round datapath: FINAL takes ark directly, ROUND adds InvMixColumns.
  always_comb begin
    isr_b = inv_shift_rows(st);
  end

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    inv_s_box u_inv_s_box (
      .value   (isr_b[i]),
      .inverse (isb_b[i])
    );
  end

  always_comb begin
    ark       = isb_b ^ rk_i;
    round_out = inv_mix_columns(ark);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm <= IDLE;
    else        fsm <= fsm_nxt;
  end

  // Next-state logic
  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE:    if (valid_i)           fsm_nxt = ROUND;
      ROUND:   if (cnt == 4'd1)       fsm_nxt = FINAL;
      FINAL:                          fsm_nxt = DONE;
      DONE:    if (valid_o && ready_i) fsm_nxt = IDLE;
      default:                        fsm_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    ready_o  = (fsm == IDLE);
    rk_idx_o = '0;
    case (fsm)
      IDLE:    rk_idx_o = 4'(NR);
      ROUND:   rk_idx_o = cnt;
      default: rk_idx_o = '0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      st      <= '0;
      state_o <= '0;
      valid_o <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (valid_i) begin
            st  <= state_i ^ rk_i;
            cnt <= 4'(NR - 1);
          end
        end
        ROUND: begin
          st <= round_out;
          if (cnt != 4'd1) cnt <= cnt - 4'd1;
        end
        FINAL: begin
          state_o <= ark;
          valid_o <= 1'b1;
        end
        DONE: begin
          if (valid_o && ready_i) valid_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/inv_cipher_core.md
# inv_cipher_core

Iterative AES-128 inverse cipher datapath. It accepts one 128-bit ciphertext block and performs the initial AddRoundKey, nine full inverse rounds and the final inverse round, one round per clock. It returns the plaintext on a valid/ready output handshake. It is the decrypt-side counterpart of the pipelined encrypt stages. Round keys come from an external, already expanded key store, which the core indexes combinationally.

## Interface
- NR, default 10, number of rounds (AES-128 only; other values unsupported).
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- valid_i  in  1  input block valid.
- ready_o  out  1  core can accept a block.
- state_i  in  128  ciphertext; byte 0 (FIPS-197 input order) in [127:120], byte i in [127-8i -: 8], column-major (i = 4·col + row).
- rk_idx_o  out  4  round-key index requested this cycle.
- rk_i  in  128  round key for rk_idx_o, same byte order, valid in the same cycle.
- valid_o  out  1  plaintext valid.
- ready_i  in  1  downstream accepts plaintext.
- state_o  out  128  plaintext, same byte order.

## Operation
- FSM states: IDLE, ROUND, FINAL, DONE.
- Round counter cnt is 4 bits.
- IDLE:
  - ready_o=1, rk_idx_o=NR.
  - On valid_i & ready_o: st ← state_i ^ rk_i; cnt ← NR-1; go to ROUND.
- ROUND:
  - rk_idx_o=cnt.
  - st ← InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ rk_i).
  - If cnt==1, go to FINAL; else cnt ← cnt-1.
- FINAL:
  - rk_idx_o=0.
  - state_o ← InvSubBytes(InvShiftRows(st)) ^ rk_i; valid_o ← 1; go to DONE.
- DONE:
  - rk_idx_o=0.
  - valid_o and state_o held stable until ready_i is seen high.
  - On valid_o & ready_i: valid_o ← 0; go to IDLE.
- ready_o = (fsm==IDLE), decoded combinationally. valid_i is ignored in every other state, with no side effects.
- InvShiftRows: row r is rotated right by r byte positions.
- InvMixColumns: per column, matrix {0e,0b,0d,09} over GF(2^8), reduction polynomial 0x11b.
- All arithmetic is bytewise XOR/GF. There are no carries and no width growth.

## Timing
- Reset values:
  - fsm=IDLE, cnt=0, st=0.
  - valid_o=0, state_o=0.
  - ready_o=1, rk_idx_o=10.
- Latency: accept on edge E0; valid_o rises after edge E0+10. That is 1 AddRoundKey edge, 9 ROUND edges and 1 FINAL edge.
- rk_idx_o sequence per block: 10 (accept cycle), 9, 8, …, 1, 0.
- Minimum block period is 12 cycles: accept, 9 ROUND, FINAL, then one DONE cycle with ready_i=1. The next accept happens in the following IDLE cycle.
- ready_i may be high before valid_o. The transfer completes on the first edge where both are high.
- Reset mid-operation: everything returns to reset values immediately, and the in-flight block is discarded with no valid_o.
- rk_i is sampled only on the edge ending the cycle in which rk_idx_o presents its index. Changes at any other time are ignored.

## Structure
- Shared package aes_pkg holds:
  - localparam NR=10.
  - FSM enum type.
  - Functions xtime, gf_mul, inv_shift_rows, inv_mix_columns, operating on 128-bit state in the byte order above.
- One sub-module, inv_s_box: 8-bit combinational inverse S-box lookup, with 16 instances over st.
- Key expansion is outside this block.

## Test plan
- FIPS-197 C.1, with rk_i driven from the expanded key 000102…0f:
  - Stimulus: state_i=69c4e0d86a7b0430d8cdb78070b4c55a; rk_idx_o=10 must return 13111d7fe3944a17f307a78b4d2b30c5.
  - Required: st after accept = 7ad5fda789ef4e272bca100b3d9ff59f.
  - Required: valid_o after 11 edges with state_o=00112233445566778899aabbccddeeff.
- rk_idx_o trace across one block → exactly 10,9,…,1,0. ready_o is low from the edge after accept until DONE completes.
- Output backpressure: hold ready_i=0 for 5 cycles after valid_o → valid_o and state_o stable. valid_i pulses during this window are ignored, with ready_o=0. Raising ready_i gives IDLE on the next edge.
- Back-to-back: two blocks, valid_i held high, ready_i=1 → second accept 12 cycles after the first. Both plaintexts match a software AES model.
- Reset mid-operation: assert rst_n low during ROUND cnt=5 → on the same cycle valid_o=0, state_o=0, ready_o=1, rk_idx_o=10. A fresh block after reset decrypts correctly.
- 200 random key/ciphertext pairs against a software model → all match, latency exactly 11 cycles each.
